fp_register_file_param: RTL and testbench

Parametrised floating-point register file for the single-cycle datapath, replacing the fixed 32×32 float file. Holds DEPTH words of WORD_W bits and serves two read ports and one write port in single mode (one word) or double mode (an even/odd register pair). It adds:
- a synchronous-reset clear sequencer,
- registered reads with write-first bypass,
- detection of misaligned double accesses.

---
 rtl/fp_register_file_param.sv | 129 ++++++++++++
 tb/tb_fp_register_file_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_register_file_param.sv
// Parametrised single/double precision float register file: two registered read
// ports with write-first bypass, one write port, a clear sequencer and misalignment flag.
module fp_register_file_param #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  dbl,
    input  logic [ADDR_W-1:0]     fs,
    input  logic [ADDR_W-1:0]     ft,
    input  logic [ADDR_W-1:0]     fd,
    input  logic [2*WORD_W-1:0]   write_data,
    output logic [2*WORD_W-1:0]   read_data1,
    output logic [2*WORD_W-1:0]   read_data2,
    output logic                  ready,
    output logic                  misalign_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake-free block: every cycle in READY is an access; nothing stalls.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   clr_idx;
    logic [IDX_W-1:0]   clr_idx_next;

    logic [WORD_W-1:0]  mem [DEPTH];

    logic               wr_legal;
    logic               wr_en;
    logic [ADDR_W:0]    fd_lo;
    logic [2*WORD_W-1:0] rd1_next;
    logic [2*WORD_W-1:0] rd2_next;
    logic               err_next;

    function automatic logic idx_legal(input logic [ADDR_W-1:0] idx, input logic d);
        return ({1'b0, idx} < (ADDR_W+1)'(DEPTH)) && !(d && idx[0]);
    endfunction

    // Word as seen after this cycle's write lands (write-first per word).
    function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W:0] w);
        if (wr_en && (w == {1'b0, fd}))
            return write_data[2*WORD_W-1:WORD_W];
        else if (wr_en && dbl && (w == fd_lo))
            return write_data[WORD_W-1:0];
        else
            return mem[w[IDX_W-1:0]];
    endfunction

    function automatic logic [2*WORD_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        if (!idx_legal(idx, dbl))
            return '0;
        else if (dbl)
            return {word_at({1'b0, idx}), word_at({1'b0, idx} + (ADDR_W+1)'(1))};
        else
            return {word_at({1'b0, idx}), {WORD_W{1'b0}}};
    endfunction

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            S_CLEAR: begin
                if (clr_idx == IDX_W'(DEPTH - 1)) begin
                    state_next   = S_READY;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx + IDX_W'(1);
                end
            end
            default: state_next = S_READY;
        endcase
    end

    always_comb begin
        fd_lo    = {1'b0, fd} + (ADDR_W+1)'(1);
        wr_legal = idx_legal(fd, dbl);
        wr_en    = we && wr_legal;
        rd1_next = read_port(fs);
        rd2_next = read_port(ft);
        err_next = (we && !wr_legal) || !idx_legal(fs, dbl) || !idx_legal(ft, dbl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CLEAR;
            clr_idx      <= '0;
            read_data1   <= '0;
            read_data2   <= '0;
            misalign_err <= 1'b0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
            if (state == S_READY) begin
                read_data1   <= rd1_next;
                read_data2   <= rd2_next;
                misalign_err <= err_next;
            end else begin
                read_data1   <= '0;
                read_data2   <= '0;
                misalign_err <= 1'b0;
            end
        end
    end

    // Array has no reset port; the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wr_en) begin
                mem[fd[IDX_W-1:0]] <= write_data[2*WORD_W-1:WORD_W];
                if (dbl)
                    mem[fd_lo[IDX_W-1:0]] <= write_data[WORD_W-1:0];
            end
        end
    end

    assign ready = (state == S_READY);

endmodule

// File: tb/tb_fp_register_file_param.sv
// Bench for fp_register_file_param: array-level reference model with an expected
// queue checked every cycle, plus directed literal checks of key scenarios.
module tb_fp_register_file_param;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int EXP_W  = 2 + 4*WORD_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  we;
    logic                  dbl;
    logic [ADDR_W-1:0]     fs;
    logic [ADDR_W-1:0]     ft;
    logic [ADDR_W-1:0]     fd;
    logic [2*WORD_W-1:0]   write_data;
    logic [2*WORD_W-1:0]   read_data1;
    logic [2*WORD_W-1:0]   read_data2;
    logic                  ready;
    logic                  misalign_err;

    int checks = 0;
    int errors = 0;

    fp_register_file_param #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .we(we), .dbl(dbl), .fs(fs), .ft(ft), .fd(fd),
        .write_data(write_data), .read_data1(read_data1), .read_data2(read_data2),
        .ready(ready), .misalign_err(misalign_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [WORD_W-1:0] m_mem [DEPTH];
    bit                model_on = 0;
    bit                m_ready;
    int                clear_pos;
    logic [2*WORD_W-1:0] e_rd1, e_rd2;
    bit                e_err;
    logic [EXP_W-1:0]  exp_q[$];

    function automatic bit legal(input int idx, input bit d);
        return (idx < DEPTH) && !(d && (idx % 2 == 1));
    endfunction

    function automatic logic [2*WORD_W-1:0] model_read(input int idx, input bit d);
        if (!legal(idx, d)) return '0;
        if (d) return {m_mem[idx], m_mem[idx+1]};
        return {m_mem[idx], {WORD_W{1'b0}}};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_on  = 1;
            m_ready   = 0;
            clear_pos = 0;
            e_rd1 = '0; e_rd2 = '0; e_err = 0;
        end else if (model_on) begin
            if (!m_ready) begin
                m_mem[clear_pos] = '0;
                clear_pos++;
                if (clear_pos == DEPTH) m_ready = 1;
                e_rd1 = '0; e_rd2 = '0; e_err = 0;
            end else begin
                // Apply the write first, then read the updated array: write-first.
                if (we && legal(int'(fd), dbl)) begin
                    m_mem[fd] = write_data[2*WORD_W-1:WORD_W];
                    if (dbl) m_mem[int'(fd)+1] = write_data[WORD_W-1:0];
                end
                e_rd1 = model_read(int'(fs), dbl);
                e_rd2 = model_read(int'(ft), dbl);
                e_err = (we && !legal(int'(fd), dbl)) || !legal(int'(fs), dbl) || !legal(int'(ft), dbl);
            end
        end
        if (model_on) exp_q.push_back({m_ready, e_err, e_rd1, e_rd2});
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [2*WORD_W-1:0] act, input logic [2*WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_ready", 64'(ready), 64'(e[EXP_W-1]));
            check("sb_misalign", 64'(misalign_err), 64'(e[EXP_W-2]));
            check("sb_rd1", read_data1, e[4*WORD_W-1:2*WORD_W]);
            check("sb_rd2", read_data2, e[2*WORD_W-1:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input bit w, input bit d, input int s, input int t, input int f,
                          input logic [2*WORD_W-1:0] data);
        @(negedge clk);
        we = w; dbl = d;
        fs = ADDR_W'(s); ft = ADDR_W'(t); fd = ADDR_W'(f);
        write_data = data;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 100);
        check(name, 64'(n), 64'(DEPTH));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; we = 0; dbl = 0; fs = '0; ft = '0; fd = '0; write_data = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_rd1", read_data1, 64'd0);
        check("reset_rd2", read_data2, 64'd0);
        check("reset_misalign", 64'(misalign_err), 64'd0);
        // Writes while clearing must be ignored.
        rst = 0; we = 1; fd = 5'd9; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_ready("ready_latency");

        access(1, 0, 0, 0, 3, 64'h40490FDB_12345678);
        access(0, 0, 3, 9, 0, 64'h0);
        settle();
        check("single_read", read_data1, 64'h40490FDB_00000000);
        check("clear_ignored_write", read_data2, 64'h0);

        access(1, 1, 6, 6, 6, 64'h400921FB_54442D18);
        settle();
        check("dbl_bypass_rd1", read_data1, 64'h400921FB_54442D18);
        check("dbl_bypass_rd2", read_data2, 64'h400921FB_54442D18);
        access(0, 0, 6, 7, 0, 64'h0);
        settle();
        check("reg6", read_data1, 64'h400921FB_00000000);
        check("reg7", read_data2, 64'h54442D18_00000000);

        access(1, 1, 0, 0, 2, 64'h11112222_33334444);
        access(1, 1, 31, 2, 7, 64'hAAAA_BBBB_CCCC_DDDD);
        settle();
        check("misalign_flag", 64'(misalign_err), 64'd1);
        check("misalign_rd1", read_data1, 64'h0);
        check("misalign_rd2", read_data2, 64'h11112222_33334444);
        access(0, 0, 7, 6, 0, 64'h0);
        settle();
        check("reg7_unchanged", read_data1, 64'h54442D18_00000000);
        check("misalign_one_cycle", 64'(misalign_err), 64'd0);
        access(0, 1, 0, 0, 7, 64'h0);
        settle();
        check("fd_illegal_no_we", 64'(misalign_err), 64'd0);

        access(1, 0, 5, 4, 5, 64'hDEADBEEF_00000000);
        settle();
        check("single_bypass", read_data1, 64'hDEADBEEF_00000000);
        check("single_other_port", read_data2, 64'h0);
        access(0, 1, 4, 6, 0, 64'h0);
        settle();
        check("pair45", read_data1, 64'h00000000_DEADBEEF);

        // Reset partway through the clear sequence restarts it.
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; we = 0;
        repeat (10) @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0; we = 1; dbl = 0; fd = 5'd3; write_data = 64'h12345678_9ABCDEF0;
        wait_ready("ready_after_midclear");
        access(0, 1, 2, 6, 0, 64'h0);
        settle();
        check("cleared_pair2", read_data1, 64'h0);
        check("cleared_pair6", read_data2, 64'h0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            we  = 1'($urandom_range(0, 1));
            dbl = 1'($urandom_range(0, 1));
            fs  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(0, 7));
            ft  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(0, 7));
            fd  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(0, 7));
            write_data = {$urandom, $urandom};
        end
        @(negedge clk); rst = 0; we = 0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
